mem_arbiter: RTL and testbench

Two-port arbiter that shares the single RV32I mock memory port between instruction fetch (IF) and the load/store unit (LS). Grants at most one access per cycle and drives the memory's addr/sel/wen/data_i. Captures combinational read data into a per-requester response register, and rejects misaligned or illegal-funct3 accesses before they reach memory. LS has priority; a starvation counter guarantees IF forward progress.

---
 rtl/mem_pkg.sv | 36 +++
 rtl/mem_align_chk.sv | 13 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mock-memory port: funct3 encodings, arbiter winner
// encoding and the access legality rule used by the arbiter, memory and LSU.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LS   = 2'd2
  } gnt_e;

  // Unsigned variants exist only for loads; halves and words must be naturally aligned.
  function automatic logic is_legal(input logic [31:0] addr,
                                    input logic [2:0]  sel,
                                    input logic        wen);
    logic ok_sel;
    logic ok_align;
    ok_sel   = 1'b0;
    ok_align = 1'b0;
    case (sel)
      F3_B:  begin ok_sel = 1'b1; ok_align = 1'b1;              end
      F3_H:  begin ok_sel = 1'b1; ok_align = ~addr[0];          end
      F3_W:  begin ok_sel = 1'b1; ok_align = (addr[1:0] == 2'b00); end
      F3_BU: begin ok_sel = ~wen; ok_align = 1'b1;              end
      F3_HU: begin ok_sel = ~wen; ok_align = ~addr[0];          end
      default: begin ok_sel = 1'b0; ok_align = 1'b0;            end
    endcase
    return ok_sel & ok_align;
  endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Combinational legality check of the request selected by the arbiter.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [2:0]  sel_i,
  input  logic        wen_i,
  output logic        legal_o
);

  assign legal_o = is_legal(addr_i, sel_i, wen_i);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single mock-memory port between instruction fetch and load/store.
// LS has priority; IF takes priority after STARVE_MAX consecutive denials.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,

  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [2:0]  ls_sel,
  input  logic        ls_wen,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,

  output logic [31:0] mem_addr,
  output logic [2:0]  mem_sel,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int             CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_q, starve_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          if_err_q, if_err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic          ls_err_q, ls_err_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;

  gnt_e          win;
  logic [31:0]   req_addr;
  logic [2:0]    req_sel;
  logic          req_wen;
  logic [31:0]   req_wdata;
  logic          req_legal;

  // No grants while in reset, so an access arriving with rst is simply dropped.
  always_comb begin
    win = GNT_NONE;
    if (!rst) begin
      if ((starve_q >= STARVE_LIM) && if_req) win = GNT_IF;
      else if (ls_req)                        win = GNT_LS;
      else if (if_req)                        win = GNT_IF;
    end
  end

  always_comb begin
    req_addr  = 32'd0;
    req_sel   = F3_W;
    req_wen   = 1'b0;
    req_wdata = 32'd0;
    case (win)
      GNT_IF: req_addr = if_addr;
      GNT_LS: begin
        req_addr  = ls_addr;
        req_sel   = ls_sel;
        req_wen   = ls_wen;
        req_wdata = ls_wdata;
      end
      default: ;
    endcase
  end

  mem_align_chk u_align_chk (
    .addr_i  (req_addr),
    .sel_i   (req_sel),
    .wen_i   (req_wen),
    .legal_o (req_legal)
  );

  assign if_gnt    = (win == GNT_IF);
  assign ls_gnt    = (win == GNT_LS);
  assign mem_addr  = req_addr;
  assign mem_sel   = req_sel;
  assign mem_wdata = req_wdata;
  assign mem_wen   = ls_gnt & req_legal & req_wen;

  always_comb begin
    if_rvalid_d = if_gnt;
    if_err_d    = if_gnt & ~req_legal;
    if_rdata_d  = (if_gnt & req_legal) ? mem_rdata : 32'd0;
    ls_rvalid_d = ls_gnt;
    ls_err_d    = ls_gnt & ~req_legal;
    ls_rdata_d  = (ls_gnt & req_legal & ~ls_wen) ? mem_rdata : 32'd0;

    starve_d = starve_q;
    if (!if_req || if_gnt)          starve_d = '0;
    else if (starve_q < STARVE_LIM) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= 32'd0;
    end else begin
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array mock memory plus a shadow reference memory
// and an arbitration model built from the priority/starvation rules.
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [31:0] ls_addr;
  logic [2:0]  ls_sel;
  logic        ls_wen;
  logic [31:0] ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_sel;
  logic        mem_wen;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  mem_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_sel(ls_sel), .ls_wen(ls_wen),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata), .ls_err(ls_err),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- mock memory (little-endian, extends per sel) ----------------
  function automatic logic [31:0] mock_read(input logic [31:0] a, input logic [2:0] s);
    logic [7:0]  wa;
    logic [31:0] w, sh;
    wa = {a[7:2], 2'b00};
    w  = {mem[wa + 8'd3], mem[wa + 8'd2], mem[wa + 8'd1], mem[wa]};
    sh = w >> {a[1:0], 3'b000};
    case (s)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return w;
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  always_comb mem_rdata = mock_read(mem_addr, mem_sel);

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
    forever begin
      @(posedge clk);
      if (mem_wen) begin
        case (mem_sel)
          3'b000: mem[mem_addr[7:0]] <= mem_wdata[7:0];
          3'b001: begin
            mem[mem_addr[7:0]]         <= mem_wdata[7:0];
            mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
          end
          default: begin
            mem[mem_addr[7:0]]         <= mem_wdata[7:0];
            mem[mem_addr[7:0] + 8'd1]  <= mem_wdata[15:8];
            mem[mem_addr[7:0] + 8'd2]  <= mem_wdata[23:16];
            mem[mem_addr[7:0] + 8'd3]  <= mem_wdata[31:24];
          end
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] s);
    case (s[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [31:0] a, input logic [2:0] s, input logic w);
    bit ok;
    ok = w ? (s inside {3'd0, 3'd1, 3'd2}) : (s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!ok) return 1'b0;
    return (a % size_of(s)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
    int n;
    logic [31:0] v;
    n = size_of(s);
    v = 32'd0;
    for (int k = 0; k < n; k++)
      v = v | (32'(ref_mem[8'(int'(a[7:0]) + k)]) << (8 * k));
    if (!s[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    logic [31:0] t;
    for (int k = 0; k < size_of(s); k++) begin
      t = d >> (8 * k);
      ref_mem[8'(int'(a[7:0]) + k)] = t[7:0];
    end
  endtask

  // ---------------- stimulus helpers (observe only, no checking) ----------------
  task automatic ls_cycle(input logic [31:0] a, input logic [2:0] s, input logic w,
                          input logic [31:0] d, output logic g, output logic mw,
                          output logic rv, output logic er, output logic [31:0] rd);
    @(negedge clk);
    ls_req = 1'b1; ls_addr = a; ls_sel = s; ls_wen = w; ls_wdata = d;
    #1;
    g  = ls_gnt;
    mw = mem_wen;
    @(posedge clk);
    #1;
    rv = ls_rvalid; er = ls_err; rd = ls_rdata;
    ls_req = 1'b0;
  endtask

  task automatic if_cycle(input logic [31:0] a, output logic g,
                          output logic rv, output logic er, output logic [31:0] rd);
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    #1;
    g = if_gnt;
    @(posedge clk);
    #1;
    rv = if_rvalid; er = if_err; rd = if_rdata;
    if_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_addr = 32'h20; ls_sel = 3'b010; ls_wen = 1'b1; ls_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    repeat (2) begin
      @(negedge clk);
      total++;
      if (if_gnt !== 1'b0 || ls_gnt !== 1'b0 || mem_wen !== 1'b0) begin
        bad++; $display("FAIL reset_gnt got if_gnt=%b ls_gnt=%b mem_wen=%b exp 0/0/0", if_gnt, ls_gnt, mem_wen);
      end
      total++;
      if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_err !== 1'b0 || ls_err !== 1'b0 ||
          if_rdata !== 32'd0 || ls_rdata !== 32'd0) begin
        bad++; $display("FAIL reset_resp got ifv=%b lsv=%b ife=%b lse=%b ifd=%h lsd=%h exp all 0",
                        if_rvalid, ls_rvalid, if_err, ls_err, if_rdata, ls_rdata);
      end
    end
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  task automatic test_if_fetch;
    logic g, rv, er;
    logic [31:0] rd, exp;
    exp = ref_load(32'h10, 3'b010);
    if_cycle(32'h10, g, rv, er, rd);
    total++;
    if (g !== 1'b1) begin bad++; $display("FAIL if_gnt got=%b exp=1", g); end
    total++;
    if (rv !== 1'b1 || er !== 1'b0 || rd !== exp) begin
      bad++; $display("FAIL if_resp got v=%b e=%b d=%h exp v=1 e=0 d=%h", rv, er, rd, exp);
    end
    if_cycle(32'h13, g, rv, er, rd);
    total++;
    if (g !== 1'b1 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL if_misaligned got g=%b v=%b e=%b d=%h exp 1/1/1/0", g, rv, er, rd);
    end
  endtask

  task automatic test_ls_store_load;
    logic g, mw, rv, er;
    logic [31:0] rd;
    ls_cycle(32'h20, 3'b010, 1'b1, 32'hDEADBEEF, g, mw, rv, er, rd);
    ref_store(32'h20, 3'b010, 32'hDEADBEEF);
    total++;
    if (g !== 1'b1 || mw !== 1'b1 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'd0) begin
      bad++; $display("FAIL sw_resp got g=%b w=%b v=%b e=%b d=%h exp 1/1/1/0/0", g, mw, rv, er, rd);
    end
    ls_cycle(32'h20, 3'b010, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (g !== 1'b1 || mw !== 1'b0 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      bad++; $display("FAIL lw_resp got g=%b w=%b v=%b e=%b d=%h exp d=deadbeef", g, mw, rv, er, rd);
    end
    ls_cycle(32'h23, 3'b000, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== 32'hFFFFFFDE || er !== 1'b0) begin
      bad++; $display("FAIL lb_0x23 got d=%h e=%b exp d=ffffffde e=0", rd, er);
    end
    ls_cycle(32'h23, 3'b100, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== 32'h000000DE || er !== 1'b0) begin
      bad++; $display("FAIL lbu_0x23 got d=%h e=%b exp d=000000de e=0", rd, er);
    end
    ls_cycle(32'h22, 3'b001, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== 32'hFFFFDEAD) begin bad++; $display("FAIL lh_0x22 got=%h exp=ffffdead", rd); end
    ls_cycle(32'h22, 3'b101, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== 32'h0000DEAD) begin bad++; $display("FAIL lhu_0x22 got=%h exp=0000dead", rd); end
    ls_cycle(32'h21, 3'b000, 1'b1, 32'h00000077, g, mw, rv, er, rd);
    ref_store(32'h21, 3'b000, 32'h00000077);
    ls_cycle(32'h20, 3'b010, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== 32'hDEAD77EF) begin bad++; $display("FAIL sb_merge got=%h exp=dead77ef", rd); end
  endtask

  task automatic test_misaligned;
    logic g, mw, rv, er;
    logic [31:0] rd, exp;
    ls_cycle(32'h22, 3'b010, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (g !== 1'b1 || mw !== 1'b0 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL lw_misaligned got g=%b w=%b v=%b e=%b d=%h exp 1/0/1/1/0", g, mw, rv, er, rd);
    end
    ls_cycle(32'h21, 3'b001, 1'b1, 32'h00001234, g, mw, rv, er, rd);
    total++;
    if (g !== 1'b1 || mw !== 1'b0 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL sh_misaligned got g=%b w=%b v=%b e=%b d=%h exp 1/0/1/1/0", g, mw, rv, er, rd);
    end
    exp = ref_load(32'h20, 3'b010);
    ls_cycle(32'h20, 3'b010, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== exp) begin bad++; $display("FAIL misaligned_nowrite got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_illegal_sel;
    logic g, mw, rv, er;
    logic [31:0] rd, exp;
    ls_cycle(32'h20, 3'b011, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (g !== 1'b1 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL load_sel011 got g=%b v=%b e=%b d=%h exp 1/1/1/0", g, rv, er, rd);
    end
    ls_cycle(32'h20, 3'b100, 1'b1, 32'h0BADF00D, g, mw, rv, er, rd);
    total++;
    if (g !== 1'b1 || mw !== 1'b0 || er !== 1'b1 || rd !== 32'd0) begin
      bad++; $display("FAIL store_sel100 got g=%b w=%b e=%b d=%h exp 1/0/1/0", g, mw, er, rd);
    end
    ls_cycle(32'h20, 3'b101, 1'b1, 32'h0BADF00D, g, mw, rv, er, rd);
    total++;
    if (mw !== 1'b0 || er !== 1'b1) begin
      bad++; $display("FAIL store_sel101 got w=%b e=%b exp 0/1", mw, er);
    end
    exp = ref_load(32'h20, 3'b010);
    ls_cycle(32'h20, 3'b010, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== exp || er !== 1'b0) begin
      bad++; $display("FAIL illegal_nowrite got d=%h e=%b exp d=%h e=0", rd, er, exp);
    end
  endtask

  task automatic test_starvation;
    bit exp_if;
    int if_run, ls_run;
    if_run = 0; ls_run = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_addr = 32'h44; ls_sel = 3'b010; ls_wen = 1'b0; ls_wdata = 32'd0;
    for (int c = 0; c < 15; c++) begin
      #1;
      exp_if = ((c % 5) == 4);
      total++;
      if (if_gnt !== exp_if || ls_gnt !== !exp_if) begin
        bad++; $display("FAIL starve_cyc%0d got if_gnt=%b ls_gnt=%b exp if_gnt=%b", c, if_gnt, ls_gnt, exp_if);
      end
      if_run = if_gnt ? 0 : if_run + 1;
      ls_run = ls_gnt ? 0 : ls_run + 1;
      @(posedge clk);
      #1;
      total++;
      if (if_rvalid !== exp_if || ls_rvalid !== !exp_if ||
          (exp_if && if_rdata !== ref_load(32'h40, 3'b010)) ||
          (!exp_if && ls_rdata !== ref_load(32'h44, 3'b010))) begin
        bad++; $display("FAIL starve_resp%0d got ifv=%b lsv=%b ifd=%h lsd=%h", c, if_rvalid, ls_rvalid, if_rdata, ls_rdata);
      end
      total++;
      if (if_run > STARVE_MAX || ls_run > STARVE_MAX) begin
        bad++; $display("FAIL starve_bound%0d got if_run=%0d ls_run=%0d exp <= %0d", c, if_run, ls_run, STARVE_MAX);
      end
      @(negedge clk);
    end
    if_req = 1'b0; ls_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid_access;
    logic g, mw, rv, er;
    logic [31:0] rd, exp;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_addr = 32'h30; ls_sel = 3'b010; ls_wen = 1'b0; ls_wdata = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1; ls_wen = 1'b1; ls_wdata = 32'h11223344;
    #1;
    total++;
    if (ls_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_wen !== 1'b0) begin
      bad++; $display("FAIL rst_mid_gnt got ls_gnt=%b if_gnt=%b mem_wen=%b exp 0/0/0", ls_gnt, if_gnt, mem_wen);
    end
    @(posedge clk);
    #1;
    total++;
    if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0 || if_err !== 1'b0 || ls_err !== 1'b0 ||
        if_rdata !== 32'd0 || ls_rdata !== 32'd0) begin
      bad++; $display("FAIL rst_mid_resp got ifv=%b lsv=%b ife=%b lse=%b ifd=%h lsd=%h exp all 0",
                      if_rvalid, ls_rvalid, if_err, ls_err, if_rdata, ls_rdata);
    end
    @(negedge clk);
    rst = 1'b0; ls_wen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (if_gnt !== (c == 4) || ls_gnt !== (c != 4)) begin
        bad++; $display("FAIL rst_starve_clear%0d got if_gnt=%b ls_gnt=%b exp if_gnt=%b", c, if_gnt, ls_gnt, c == 4);
      end
      @(negedge clk);
    end
    if_req = 1'b0; ls_req = 1'b0;
    exp = ref_load(32'h30, 3'b010);
    ls_cycle(32'h30, 3'b010, 1'b0, 32'd0, g, mw, rv, er, rd);
    total++;
    if (rd !== exp) begin bad++; $display("FAIL rst_mid_nowrite got=%h exp=%h", rd, exp); end
  endtask

  task automatic test_random;
    bit if_p, ls_p, win_if, win_ls, leg;
    logic [31:0] if_a, ls_a, ls_d, exp_if_d, exp_ls_d;
    logic [2:0]  ls_s;
    logic        ls_w;
    int starve;
    if_p = 0; ls_p = 0; starve = 0;
    if_a = 0; ls_a = 0; ls_d = 0; ls_s = 0; ls_w = 0;
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!if_p && $urandom_range(0, 3) != 0) begin
        if_p = 1; if_a = {24'd0, 8'($urandom)};
        if ($urandom_range(0, 3) != 0) if_a[1:0] = 2'b00;
      end
      if (!ls_p && $urandom_range(0, 2) != 0) begin
        ls_p = 1; ls_a = {24'd0, 8'($urandom)}; ls_s = 3'($urandom_range(0, 7));
        ls_w = 1'($urandom); ls_d = $urandom;
        if ($urandom_range(0, 1) != 0) ls_a[1:0] = 2'b00;
      end
      if_req = if_p; if_addr = if_a;
      ls_req = ls_p; ls_addr = ls_a; ls_sel = ls_s; ls_wen = ls_w; ls_wdata = ls_d;
      win_if = if_p && (starve >= STARVE_MAX || !ls_p);
      win_ls = ls_p && !win_if;
      leg = win_if ? ref_legal(if_a, 3'b010, 1'b0) : ref_legal(ls_a, ls_s, ls_w);
      exp_if_d = (win_if && leg) ? ref_load(if_a, 3'b010) : 32'd0;
      exp_ls_d = (win_ls && leg && !ls_w) ? ref_load(ls_a, ls_s) : 32'd0;
      #1;
      total++;
      if (if_gnt !== win_if || ls_gnt !== win_ls || mem_wen !== (win_ls && leg && ls_w)) begin
        bad++; $display("FAIL rnd_gnt%0d got if=%b ls=%b wen=%b exp if=%b ls=%b wen=%b",
                        c, if_gnt, ls_gnt, mem_wen, win_if, win_ls, win_ls && leg && ls_w);
      end
      @(posedge clk);
      #1;
      total++;
      if (if_rvalid !== win_if || if_err !== (win_if && !leg) || if_rdata !== exp_if_d) begin
        bad++; $display("FAIL rnd_if_resp%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                        c, if_rvalid, if_err, if_rdata, win_if, win_if && !leg, exp_if_d);
      end
      total++;
      if (ls_rvalid !== win_ls || ls_err !== (win_ls && !leg) || ls_rdata !== exp_ls_d) begin
        bad++; $display("FAIL rnd_ls_resp%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h",
                        c, ls_rvalid, ls_err, ls_rdata, win_ls, win_ls && !leg, exp_ls_d);
      end
      if (win_ls && leg && ls_w) ref_store(ls_a, ls_s, ls_d);
      starve = (if_p && !win_if) ? starve + 1 : 0;
      if (win_if) if_p = 0;
      if (win_ls) ls_p = 0;
    end
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_addr = 32'd0; ls_sel = 3'b010; ls_wen = 1'b0; ls_wdata = 32'd0;
    test_reset();
    test_if_fetch();
    test_ls_store_load();
    test_misaligned();
    test_illegal_sel();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
